// File: rtl/dealer_pkg.sv
// Shared definitions for the card dealer arbiter: FSM encoding, LFSR constants and
// card-value width helpers.
package dealer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_DRAW    = 2'd2,
    ST_GRANT   = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hD824;
  localparam int          NVAL_DEFAULT = 8;

  // Bits needed to hold card values 0..nval (0 means "no card").
  function automatic int card_w(input int nval);
    return $clog2(nval + 1);
  endfunction

  localparam int CARD_W   = card_w(NVAL_DEFAULT);
  localparam int REMAIN_W = 6;

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR (right shift, tap mask from dealer_pkg); it never
// stalls, so the draw sequence also depends on how long the game sat idle.
module card_lfsr
  import dealer_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/card_dealer_arbiter.sv
// Round-robin A/B arbiter dealing values from a finite shoe sampled by an LFSR.
// Build macro DEALER_FORCE_EN adds FORCE_VALID/FORCE_CARD to override the draw candidate.
module card_dealer_arbiter
  import dealer_pkg::*;
#(
  parameter int          NVAL      = NVAL_DEFAULT,
  parameter int          COPIES    = 4,
  parameter int          MAX_RETRY = 4,
  parameter logic [15:0] SEED      = DEFAULT_SEED
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                REQ_A,
  input  logic                REQ_B,
  input  logic                SHUFFLE,
`ifdef DEALER_FORCE_EN
  input  logic                FORCE_VALID,
  input  logic [CARD_W-1:0]   FORCE_CARD,
`endif
  output logic                GNT_A,
  output logic                GNT_B,
  output logic [CARD_W-1:0]   CARD,
  output logic [REMAIN_W-1:0] REMAIN,
  output logic                BUSY
);

  localparam int IDX_W   = (NVAL > 1) ? $clog2(NVAL) : 1;
  localparam int UCNT_W  = 3;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [UCNT_W-1:0]   COPIES_U   = UCNT_W'(COPIES);
  localparam logic [CARD_W-1:0]   NVAL_C     = CARD_W'(NVAL);
  localparam logic [REMAIN_W-1:0] FULL       = REMAIN_W'(NVAL * COPIES);
  localparam logic [RETRY_W-1:0]  RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  state_t                state;
  state_t                state_nxt;
  logic [15:0]           lfsr;
  logic                  unused_lfsr_hi;
  logic [UCNT_W-1:0]     used [NVAL];
  logic [NVAL-1:0]       has_left;
  logic [REMAIN_W-1:0]   remain;
  logic [RETRY_W-1:0]    retry;
  logic                  pend;
  logic                  win_vld;
  logic                  win_b;
  logic                  last_b;
  logic                  any_req;
  logic                  pick_b;
  logic [CARD_W-1:0]     lfsr_cand;
  logic [CARD_W-1:0]     cand;
  logic                  cand_in_range;
  logic [IDX_W-1:0]      cand_idx;
  logic                  cand_ok;
  logic [CARD_W-1:0]     scan_val;
  logic                  draw_done;
  logic [CARD_W-1:0]     card_q;
  logic [IDX_W-1:0]      grant_idx;

  // First value at or above 'start' (0-based, wrapping) that the shoe still holds.
  function automatic logic [CARD_W-1:0] scan_up(input logic [NVAL-1:0] left,
                                                input int start);
    logic [CARD_W-1:0] val;
    logic              found;
    val   = CARD_W'(1);
    found = 1'b0;
    for (int k = 0; k < NVAL; k++) begin
      if (!found && left[(start + k) % NVAL]) begin
        found = 1'b1;
        val   = CARD_W'(((start + k) % NVAL) + 1);
      end
    end
    return val;
  endfunction

  card_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (CLK),
    .rst  (RESET),
    .lfsr (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:3];
  assign lfsr_cand      = CARD_W'(lfsr[2:0]) + CARD_W'(1);

`ifdef DEALER_FORCE_EN
  assign cand = FORCE_VALID ? FORCE_CARD : lfsr_cand;
`else
  assign cand = lfsr_cand;
`endif

  always_comb begin
    has_left = '0;
    for (int v = 0; v < NVAL; v++) begin
      has_left[v] = (used[v] < COPIES_U);
    end
  end

  // Out-of-range candidates behave as exhausted and scan from value 1.
  assign cand_in_range = (cand != '0) && (cand <= NVAL_C);
  assign cand_idx      = IDX_W'(cand - CARD_W'(1));
  assign cand_ok       = cand_in_range && has_left[cand_idx];
  assign scan_val      = scan_up(has_left, cand_in_range ? (int'(cand) - 1) : 0);
  assign draw_done     = (state == ST_DRAW) && (cand_ok || (retry == RETRY_LAST));

  assign any_req   = REQ_A | REQ_B;
  assign pick_b    = REQ_B & (~REQ_A | ~last_b);
  assign grant_idx = IDX_W'(card_q - CARD_W'(1));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pend || SHUFFLE) begin
          state_nxt = ST_SHUFFLE;
        end else if (any_req) begin
          state_nxt = (remain == '0) ? ST_SHUFFLE : ST_DRAW;
        end
      end
      ST_SHUFFLE: state_nxt = win_vld ? ST_DRAW : ST_IDLE;
      ST_DRAW:    if (draw_done) state_nxt = ST_GRANT;
      ST_GRANT:   state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    GNT_A  = (state == ST_GRANT) && !win_b;
    GNT_B  = (state == ST_GRANT) && win_b;
    CARD   = (state == ST_GRANT) ? card_q : '0;
    REMAIN = remain;
    BUSY   = (state != ST_IDLE);
  end

  // Winner latch, round-robin pointer and pending shuffle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      win_vld <= 1'b0;
      win_b   <= 1'b0;
      last_b  <= 1'b1;
      pend    <= 1'b0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        win_vld <= 1'b1;
        win_b   <= pick_b;
      end else if (state == ST_GRANT) begin
        win_vld <= 1'b0;
        last_b  <= win_b;
      end
      if (state == ST_SHUFFLE) begin
        pend <= 1'b0;
      end else if (SHUFFLE) begin
        pend <= 1'b1;
      end
    end
  end

  // Retry counter is zero whenever the FSM is outside ST_DRAW
  always_ff @(posedge CLK) begin
    if (RESET || state != ST_DRAW) begin
      retry <= '0;
    end else if (!cand_ok) begin
      retry <= retry + RETRY_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (draw_done) begin
      card_q <= cand_ok ? cand : scan_val;
    end
  end

  // Shoe bookkeeping
  always_ff @(posedge CLK) begin
    if (RESET || state == ST_SHUFFLE) begin
      for (int v = 0; v < NVAL; v++) begin
        used[v] <= '0;
      end
      remain <= FULL;
    end else if (state == ST_GRANT) begin
      used[grant_idx] <= used[grant_idx] + UCNT_W'(1);
      remain          <= remain - REMAIN_W'(1);
    end
  end

endmodule

// File: tb/tb_card_dealer_arbiter.sv
// Directed bench for card_dealer_arbiter; the force-candidate scenario is built only
// when DEALER_FORCE_EN is defined.
module tb_card_dealer_arbiter;

  logic       CLK;
  logic       RESET;
  logic       REQ_A;
  logic       REQ_B;
  logic       SHUFFLE;
`ifdef DEALER_FORCE_EN
  logic       FORCE_VALID;
  logic [3:0] FORCE_CARD;
`endif
  logic       GNT_A;
  logic       GNT_B;
  logic [3:0] CARD;
  logic [5:0] REMAIN;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  card_dealer_arbiter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .REQ_A       (REQ_A),
    .REQ_B       (REQ_B),
    .SHUFFLE     (SHUFFLE),
`ifdef DEALER_FORCE_EN
    .FORCE_VALID (FORCE_VALID),
    .FORCE_CARD  (FORCE_CARD),
`endif
    .GNT_A       (GNT_A),
    .GNT_B       (GNT_B),
    .CARD        (CARD),
    .REMAIN      (REMAIN),
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET   = 1'b1;
    REQ_A   = 1'b0;
    REQ_B   = 1'b0;
    SHUFFLE = 1'b0;
`ifdef DEALER_FORCE_EN
    FORCE_VALID = 1'b0;
    FORCE_CARD  = 4'd0;
`endif
    step();
    step();
    RESET = 1'b0;
  endtask

  // Raise one request in an idle cycle, wait for its grant, drop it and step once more.
  task automatic do_req(input bit to_b, output int card, output int lat);
    if (to_b) REQ_B = 1'b1;
    else      REQ_A = 1'b1;
    lat  = 0;
    card = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      step();
      if (to_b ? GNT_B : GNT_A) begin
        lat  = i;
        card = int'(CARD);
      end
    end
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    if (lat == 0) chk("req_timeout", 0, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int card;
    int lat;
    int got;
    int hist [9];

    // Reset state
    RESET   = 1'b1;
    REQ_A   = 1'b0;
    REQ_B   = 1'b0;
    SHUFFLE = 1'b0;
`ifdef DEALER_FORCE_EN
    FORCE_VALID = 1'b0;
    FORCE_CARD  = 4'd0;
`endif
    step();
    step();
    chk("rst_gnt_a", GNT_A, 0);
    chk("rst_gnt_b", GNT_B, 0);
    chk("rst_card", CARD, 0);
    chk("rst_remain", REMAIN, 32);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;

    // Single A request: grant two cycles later
    REQ_A = 1'b1;
    chk("t2_busy_t", BUSY, 0);
    step();
    chk("t2_busy_t1", BUSY, 1);
    chk("t2_gnt_t1", GNT_A, 0);
    step();
    chk("t2_gnt_a", GNT_A, 1);
    chk("t2_gnt_b", GNT_B, 0);
    chk("t2_busy_t2", BUSY, 1);
    chk("t2_card_rng", int'(CARD >= 4'd1 && CARD <= 4'd8), 1);
    REQ_A = 1'b0;
    step();
    chk("t2_remain", REMAIN, 31);
    chk("t2_busy_after", BUSY, 0);
    chk("t2_card_idle", CARD, 0);

    // Reset in the middle of a draw aborts it
    do_reset();
    REQ_A = 1'b1;
    step();
    chk("abort_busy", BUSY, 1);
    RESET = 1'b1;
    step();
    REQ_A = 1'b0;
    chk("abort_gnt", GNT_A, 0);
    chk("abort_busy_rst", BUSY, 0);
    RESET = 1'b0;
    step();
    chk("abort_gnt2", GNT_A, 0);
    chk("abort_remain", REMAIN, 32);

    // Both requesting: strict alternation starting with A
    do_reset();
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      if (GNT_A || GNT_B) begin
        chk("rr_one_hot", int'(GNT_A && GNT_B), 0);
        chk("rr_order_b", GNT_B, got % 2);
        got++;
      end
    end
    chk("rr_count", got, 4);
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    step();
    chk("rr_remain", REMAIN, 28);

`ifdef DEALER_FORCE_EN
    // Forced candidate 5: four copies, then scan to 6 after all retries
    do_reset();
    FORCE_VALID = 1'b1;
    FORCE_CARD  = 4'd5;
    for (int n = 0; n < 4; n++) begin
      do_req(1'b0, card, lat);
      chk("frc_card", card, 5);
      chk("frc_lat", lat, 2);
    end
    chk("frc_remain4", REMAIN, 28);
    do_req(1'b0, card, lat);
    chk("frc_scan_card", card, 6);
    chk("frc_scan_lat", lat, 5);
    chk("frc_remain5", REMAIN, 27);
    FORCE_VALID = 1'b0;
`endif

    // Empty the shoe: every value exactly COPIES times, then auto-shuffle
    do_reset();
    for (int v = 0; v < 9; v++) hist[v] = 0;
    for (int n = 0; n < 32; n++) begin
      do_req(1'b0, card, lat);
      chk("drain_lat", int'(lat >= 2 && lat <= 5), 1);
      if (card >= 1 && card <= 8) hist[card]++;
      else chk("drain_card_rng", card, 1);
    end
    chk("drain_remain", REMAIN, 0);
    for (int v = 1; v <= 8; v++) chk($sformatf("drain_hist%0d", v), hist[v], 4);
    do_req(1'b1, card, lat);
    chk("reshuf_lat", lat, 3);
    chk("reshuf_card_rng", int'(card >= 1 && card <= 8), 1);
    chk("reshuf_remain", REMAIN, 31);

    // SHUFFLE during a draw is deferred until the grant completes
    do_reset();
    for (int n = 0; n < 10; n++) do_req(1'b0, card, lat);
    chk("pend_remain10", REMAIN, 22);
    REQ_A = 1'b1;
    step();
    chk("pend_in_draw", BUSY, 1);
    SHUFFLE = 1'b1;
    step();
    SHUFFLE = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      if (GNT_A) got = 1;
      else step();
    end
    chk("pend_gnt", got, 1);
    REQ_A = 1'b0;
    step();
    chk("pend_remain_after", REMAIN, 21);
    step();
    chk("pend_shuffle_busy", BUSY, 1);
    step();
    chk("pend_remain_full", REMAIN, 32);
    chk("pend_idle", BUSY, 0);
    step();
    chk("pend_stay_idle", BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
